cardinal_nic: RTL

Network interface controller on the processor-side NIC port of the four-stage cardinal CPU, and the responder for its `nicEn`/`nicWrEn` load/store accesses. It holds one single-entry input channel buffer, filled by the router, and one single-entry output channel buffer, drained to the router. It exposes both buffers and their full/empty status through a 2-bit register address space. On the network side it moves 64-bit packets with a send/ready handshake, gated by an even/odd polarity rule.

---
 rtl/cardinal_nic_if.sv | 42 ++++
 rtl/cardinal_nic.sv | 114 +++++++++++
 2 files changed

// File: rtl/cardinal_nic_if.sv
// ============================================================================
//  Module      : cardinal_nic_if
//  Description : Bus bundle between the cardinal NIC, the CPU load/store
//                port and the router. The NIC connects through the slave
//                modport; the CPU/router side (or a bench) uses master.
//  Ports       : addr, d_in, d_out, nicEn, nicWrEn          (CPU side)
//                net_si, net_ri, net_di, net_so, net_ro,
//                net_do, net_polarity                       (router side)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cardinal_nic_if #(
  parameter int DATA_WIDTH = 64
);
  logic [1:0]            addr;
  logic [0:DATA_WIDTH-1] d_in;
  logic [0:DATA_WIDTH-1] d_out;
  logic                  nicEn;
  logic                  nicWrEn;
  logic                  net_si;
  logic                  net_ri;
  logic [0:DATA_WIDTH-1] net_di;
  logic                  net_so;
  logic                  net_ro;
  logic [0:DATA_WIDTH-1] net_do;
  logic                  net_polarity;

  modport slave (
    input  addr, d_in, nicEn, nicWrEn,
    input  net_si, net_di, net_ro, net_polarity,
    output d_out, net_ri, net_so, net_do
  );

  modport master (
    output addr, d_in, nicEn, nicWrEn,
    output net_si, net_di, net_ro, net_polarity,
    input  d_out, net_ri, net_so, net_do
  );
endinterface

`default_nettype wire

// File: rtl/cardinal_nic.sv
// ============================================================================
//  Module      : cardinal_nic
//  Description : Network interface controller for the cardinal CPU. One
//                single-entry input buffer (filled by the router) and one
//                single-entry output buffer (drained to the router), both
//                visible to the CPU through a 2-bit register map:
//                  00 input buffer (read clears input-full)
//                  01 input status  {63'b0, in_full}
//                  10 output buffer (write fills when empty)
//                  11 output status {63'b0, out_full}
//  Ports       : clk, reset (synchronous, active-high)
//                bus : cardinal_nic_if.slave (CPU access + router channels)
//  Options     : NIC_POLARITY_EN - when defined, the output packet is only
//                sent while its bit 0 matches net_polarity.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cardinal_nic #(
  parameter int DATA_WIDTH = 64
) (
  input wire logic     clk,
  input wire logic     reset,
  cardinal_nic_if.slave bus
);

  localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

  logic [0:DATA_WIDTH-1] in_buf;
  logic                  in_full;
  logic [0:DATA_WIDTH-1] out_buf;
  logic                  out_full;
  logic [0:DATA_WIDTH-1] d_out_q;

  logic cpu_rd;
  logic cpu_wr;
  logic polarity_ok;
  logic accept_in;
  logic send_out;

  assign cpu_rd = bus.nicEn & ~bus.nicWrEn;
  assign cpu_wr = bus.nicEn &  bus.nicWrEn;

`ifdef NIC_POLARITY_EN
  // Bit 0 of the packet selects the virtual channel; it may only leave
  // during the router phase of matching parity.
  assign polarity_ok = (out_buf[0] == bus.net_polarity);
`else
  logic unused_polarity;
  assign unused_polarity = bus.net_polarity;
  assign polarity_ok     = 1'b1;
`endif

  // Handshakes are gated by reset so nothing is exchanged while the
  // buffers are being cleared.
  assign accept_in = bus.net_si & ~in_full & ~reset;
  assign send_out  = out_full & bus.net_ro & polarity_ok & ~reset;

  assign bus.net_ri = ~in_full & ~reset;
  assign bus.net_so = send_out;
  assign bus.net_do = out_buf;
  assign bus.d_out  = d_out_q;

  // Input channel and CPU read port. A fill cannot coincide with a
  // read-clear because net_ri is low whenever in_full is set, so the router
  // packet offered during a read-clear cycle lands one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_buf  <= '0;
      in_full <= 1'b0;
      d_out_q <= '0;
    end else begin
      if (accept_in) begin
        in_buf  <= bus.net_di;
        in_full <= 1'b1;
      end
      if (cpu_rd) begin
        case (bus.addr)
          ADDR_IN_BUF: begin
            d_out_q <= in_buf;
            if (in_full) begin
              in_full <= 1'b0;
            end
          end
          ADDR_IN_STAT:  d_out_q <= {{(DATA_WIDTH-1){1'b0}}, in_full};
          ADDR_OUT_BUF:  d_out_q <= out_buf;
          ADDR_OUT_STAT: d_out_q <= {{(DATA_WIDTH-1){1'b0}}, out_full};
          default:       d_out_q <= d_out_q;
        endcase
      end
    end
  end

  // Output channel. A write only lands in an empty buffer; the second cycle
  // of the CPU's two-cycle store sees out_full set and is dropped, and a
  // write racing a send is dropped too because out_full was still set.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_buf  <= '0;
      out_full <= 1'b0;
    end else if (send_out) begin
      out_full <= 1'b0;
    end else if (cpu_wr && (bus.addr == ADDR_OUT_BUF) && !out_full) begin
      out_buf  <= bus.d_in;
      out_full <= 1'b1;
    end
  end

endmodule

`default_nettype wire
